// File: rtl/mdio_pkg.sv
// Shared MDIO Clause-22 encodings, frame geometry and FSM state type.
package mdio_pkg;

  localparam int PREAMBLE_LEN = 32;
  localparam int FRAME_LEN    = 64;

  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] TA_WRITE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA
  } state_e;

  // Read frames release the pad from TA onward, so those positions are just ones.
  function automatic logic [FRAME_LEN-1:0] build_frame(input logic rd,
                                                       input logic [4:0] pa,
                                                       input logic [4:0] ra,
                                                       input logic [15:0] wd);
    return {{PREAMBLE_LEN{1'b1}}, ST_CODE, (rd ? OP_READ : OP_WRITE), pa, ra,
            (rd ? 2'b11 : TA_WRITE), (rd ? 16'hFFFF : wd)};
  endfunction

endpackage

// File: rtl/mdio_master_if.sv
// Request/response bus between a host and mdio_master.
// Carries no_pre only when MDIO_PREAMBLE_SUPPRESS_EN is defined.
interface mdio_master_if;
  logic        start;
  logic        op_read;
  logic [4:0]  phy_addr;
  logic [4:0]  reg_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic [15:0] rd_data;
  logic        rd_err;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  logic        no_pre;

  modport master (output start, op_read, phy_addr, reg_addr, wr_data, no_pre,
                  input  busy, done, rd_data, rd_err);
  modport slave  (input  start, op_read, phy_addr, reg_addr, wr_data, no_pre,
                  output busy, done, rd_data, rd_err);
`else
  modport master (output start, op_read, phy_addr, reg_addr, wr_data,
                  input  busy, done, rd_data, rd_err);
  modport slave  (input  start, op_read, phy_addr, reg_addr, wr_data,
                  output busy, done, rd_data, rd_err);
`endif
endinterface

// File: rtl/mdc_clk_gen.sv
// MDC divider: down-counter over CLK_DIV cycles per half-period, strobing
// mdc_rise at the end of the low half and bit_start at the end of the high half.
module mdc_clk_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic load,
  output logic bit_start,
  output logic mdc_rise
);

  logic [7:0] cnt;
  logic       phase;
  logic       tc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= 8'd0;
      phase <= 1'b0;
    end else if (load) begin
      cnt   <= 8'(CLK_DIV - 1);
      phase <= 1'b0;
    end else if (!run) begin
      cnt   <= 8'd0;
      phase <= 1'b0;
    end else if (cnt == 8'd0) begin
      cnt   <= 8'(CLK_DIV - 1);
      phase <= ~phase;
    end else begin
      cnt <= cnt - 8'd1;
    end
  end

  assign tc        = run && (cnt == 8'd0);
  assign mdc_rise  = tc && !phase;
  assign bit_start = tc && phase;

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO management master (frame FSM, pad control, read capture).
// Optional MDIO_PREAMBLE_SUPPRESS_EN adds bus.no_pre to skip the 32-bit preamble.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = 10
) (
  input  logic         clk,
  input  logic         rst,
  mdio_master_if.slave bus,
  output logic         mdc,
  output logic         mdio_o,
  output logic         mdio_t,
  input  logic         mdio_i
);

  // state  | meaning
  // S_IDLE | waiting for start, pad released, mdc low
  // S_PRE  | 32 preamble ones
  // S_HDR  | ST, OP, PHY and register address (14 bits)
  // S_TA   | turnaround (2 bits); reads release the pad here
  // S_DATA | 16 payload bits, then done
  state_e          state;
  logic [4:0]      bit_cnt;
  logic [63:0]     tx_sr;
  logic [15:0]     rx_sr;
  logic            op_read_q;
  logic            ta_q;
  logic            busy_q;
  logic            done_q;
  logic [15:0]     rd_data_q;
  logic            rd_err_q;
  logic            accept;
  logic            skip_pre;
  logic            bit_start;
  logic            mdc_rise;
  logic [63:0]     frame;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  assign skip_pre = bus.no_pre;
`else
  assign skip_pre = 1'b0;
`endif

  assign accept = (state == S_IDLE) && !done_q && bus.start;
  assign frame  = build_frame(bus.op_read, bus.phy_addr, bus.reg_addr, bus.wr_data);

  mdc_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk       (clk),
    .rst       (rst),
    .run       (busy_q),
    .load      (accept),
    .bit_start (bit_start),
    .mdc_rise  (mdc_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= 5'd0;
      tx_sr     <= '1;
      rx_sr     <= 16'h0000;
      op_read_q <= 1'b0;
      ta_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= 16'h0000;
      rd_err_q  <= 1'b0;
      mdc       <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_t    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == S_IDLE) begin
        if (accept) begin
          busy_q    <= 1'b1;
          op_read_q <= bus.op_read;
          mdio_t    <= 1'b1;
          mdc       <= 1'b0;
          if (skip_pre) begin
            state   <= S_HDR;
            bit_cnt <= 5'd13;
            mdio_o  <= frame[31];
            tx_sr   <= {frame[30:0], {33{1'b1}}};
          end else begin
            state   <= S_PRE;
            bit_cnt <= 5'(PREAMBLE_LEN - 1);
            mdio_o  <= frame[63];
            tx_sr   <= {frame[62:0], 1'b1};
          end
        end
      end else begin
        if (mdc_rise) begin
          mdc <= 1'b1;
          if (state == S_TA && bit_cnt == 5'd0) ta_q <= mdio_i;
          if (state == S_DATA) rx_sr <= {rx_sr[14:0], mdio_i};
        end
        if (bit_start) begin
          mdc    <= 1'b0;
          mdio_o <= tx_sr[63];
          tx_sr  <= {tx_sr[62:0], 1'b1};
          if (bit_cnt != 5'd0) begin
            bit_cnt <= bit_cnt - 5'd1;
          end else begin
            case (state)
              S_PRE: begin
                state   <= S_HDR;
                bit_cnt <= 5'd13;
              end
              S_HDR: begin
                state   <= S_TA;
                bit_cnt <= 5'd1;
                if (op_read_q) mdio_t <= 1'b0;
              end
              S_TA: begin
                state   <= S_DATA;
                bit_cnt <= 5'd15;
              end
              default: begin
                state   <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                mdio_o  <= 1'b1;
                mdio_t  <= 1'b0;
                if (op_read_q) begin
                  rd_data_q <= rx_sr;
                  rd_err_q  <= ta_q;
                end
              end
            endcase
          end
        end
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_data = rd_data_q;
  assign bus.rd_err  = rd_err_q;

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master at CLK_DIV=2 with a cycle-indexed PHY model.
module tb_mdio_master;

  logic clk;
  logic rst;
  logic mdc;
  logic mdio_o;
  logic mdio_t;
  logic mdio_i;

  int total;
  int passed;
  int fails;

  mdio_master_if bus();

  mdio_master #(.CLK_DIV(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .mdc    (mdc),
    .mdio_o (mdio_o),
    .mdio_t (mdio_t),
    .mdio_i (mdio_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one frame and observes it cycle by cycle; c counts cycles after the accepting edge.
  task automatic run_frame(input bit rd, input logic [4:0] pa, input logic [4:0] ra,
                           input logic [15:0] wd, input logic [63:0] resp,
                           input int pulse_bit, input int rst_bit, input bit poke_done,
                           output logic [63:0] cap_o, output logic [63:0] cap_t,
                           output int busy_len, output int done_cnt, output int done_at,
                           output int glitch);
    logic cur;
    logic rst_ok;
    cap_o = '0; cap_t = '0; busy_len = 0; done_cnt = 0; done_at = -1; glitch = 0; cur = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.op_read = rd; bus.phy_addr = pa; bus.reg_addr = ra; bus.wr_data = wd;
    mdio_i = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 300; c++) begin
      int k;
      k = c / 4;
      bus.start = 1'b0;
      if (rst_bit >= 0 && c == 4 * rst_bit) begin
        rst = 1'b1;
        #1;
        rst_ok = (bus.busy === 1'b0) && (bus.done === 1'b0) && (bus.rd_data === 16'h0000) &&
                 (bus.rd_err === 1'b0) && (mdc === 1'b0) && (mdio_o === 1'b1) && (mdio_t === 1'b0);
        chk("rst_midframe_outputs", {63'd0, rst_ok}, 64'd1);
      end
      if (rst_bit >= 0 && c == 4 * rst_bit + 3) rst = 1'b0;
      if (bus.busy === 1'b1) busy_len++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
      if (k < 64 && bus.busy === 1'b1) begin
        if (c % 4 == 1) begin
          cap_o[63-k] = mdio_o;
          cap_t[63-k] = mdio_t;
        end
        if (c % 4 == 0) cur = mdio_o;
        else if (mdio_o !== cur) glitch++;
        if (mdc !== ((c % 4) >= 2)) glitch++;
      end
      mdio_i = (k < 64) ? resp[63-k] : 1'b1;
      if (pulse_bit >= 0 && c == 4 * pulse_bit) begin
        bus.start = 1'b1; bus.op_read = ~rd; bus.phy_addr = 5'h1F;
        bus.reg_addr = 5'h1F; bus.wr_data = 16'hDEAD;
      end
      if (poke_done && bus.done === 1'b1) bus.start = 1'b1;
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  logic [63:0] cap_o;
  logic [63:0] cap_t;
  int busy_len;
  int done_cnt;
  int done_at;
  int glitch;

  initial begin
    total = 0; passed = 0; fails = 0;
    rst = 1'b1; mdio_i = 1'b1;
    bus.start = 1'b0; bus.op_read = 1'b0; bus.phy_addr = 5'h00; bus.reg_addr = 5'h00;
    bus.wr_data = 16'h0000;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    bus.no_pre = 1'b0;
`endif
    #3;
    chk("reset_busy",    {63'd0, bus.busy},   64'd0);
    chk("reset_done",    {63'd0, bus.done},   64'd0);
    chk("reset_rd_data", {48'd0, bus.rd_data}, 64'd0);
    chk("reset_rd_err",  {63'd0, bus.rd_err}, 64'd0);
    chk("reset_mdc",     {63'd0, mdc},        64'd0);
    chk("reset_mdio_o",  {63'd0, mdio_o},     64'd1);
    chk("reset_mdio_t",  {63'd0, mdio_t},     64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Write phy 01 reg 00 data 1140
    run_frame(1'b0, 5'h01, 5'h00, 16'h1140, '1, -1, -1, 1'b0,
              cap_o, cap_t, busy_len, done_cnt, done_at, glitch);
    chk("wr_frame",    cap_o, 64'hFFFF_FFFF_5082_1140);
    chk("wr_mdio_t",   cap_t, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wr_busy_len", 64'(busy_len), 64'd256);
    chk("wr_done_cnt", 64'(done_cnt), 64'd1);
    chk("wr_done_at",  64'(done_at),  64'd256);
    chk("wr_timing",   64'(glitch),   64'd0);
    chk("wr_rd_data_kept", {48'd0, bus.rd_data}, 64'd0);
    chk("idle_pins", {61'd0, mdc, mdio_o, mdio_t}, 64'b010);

    // Read phy 02 reg 03, PHY drives TA bit 2 = 0 and 0D81; start poked during done
    run_frame(1'b1, 5'h02, 5'h03, 16'h0000, {{47{1'b1}}, 1'b0, 16'h0D81}, -1, -1, 1'b1,
              cap_o, cap_t, busy_len, done_cnt, done_at, glitch);
    chk("rd_header",   {18'd0, cap_o[63:18]}, {18'd0, 32'hFFFF_FFFF, 14'b01_10_00010_00011});
    chk("rd_mdio_t",   cap_t, {{46{1'b1}}, 18'd0});
    chk("rd_data",     {48'd0, bus.rd_data}, 64'h0D81);
    chk("rd_err",      {63'd0, bus.rd_err},  64'd0);
    chk("rd_busy_len_start_in_done", 64'(busy_len), 64'd256);
    chk("rd_done_cnt", 64'(done_cnt), 64'd1);
    chk("rd_timing",   64'(glitch),   64'd0);

    // Read with no PHY: line floats high
    run_frame(1'b1, 5'h04, 5'h01, 16'h0000, '1, -1, -1, 1'b0,
              cap_o, cap_t, busy_len, done_cnt, done_at, glitch);
    chk("nophy_rd_data", {48'd0, bus.rd_data}, 64'hFFFF);
    chk("nophy_rd_err",  {63'd0, bus.rd_err},  64'd1);

    // Write with a stray start at bit 20
    run_frame(1'b0, 5'h0A, 5'h15, 16'hA5C3, '1, 20, -1, 1'b0,
              cap_o, cap_t, busy_len, done_cnt, done_at, glitch);
    chk("pulse_frame",    cap_o, 64'hFFFF_FFFF_5556_A5C3);
    chk("pulse_done_cnt", 64'(done_cnt), 64'd1);
    chk("pulse_busy_len", 64'(busy_len), 64'd256);
    chk("wr_keeps_rd_data", {48'd0, bus.rd_data}, 64'hFFFF);
    chk("wr_keeps_rd_err",  {63'd0, bus.rd_err},  64'd1);

    // Reset at bit 40, then a clean write
    run_frame(1'b0, 5'h01, 5'h02, 16'h3333, '1, -1, 40, 1'b0,
              cap_o, cap_t, busy_len, done_cnt, done_at, glitch);
    chk("rst_no_done",  64'(done_cnt), 64'd0);
    chk("rst_busy_len", 64'(busy_len), 64'd160);
    run_frame(1'b0, 5'h1F, 5'h1F, 16'h0000, '1, -1, -1, 1'b0,
              cap_o, cap_t, busy_len, done_cnt, done_at, glitch);
    chk("post_rst_frame",   cap_o, 64'hFFFF_FFFF_5FFE_0000);
    chk("post_rst_done_at", 64'(done_at), 64'd256);
    chk("post_rst_timing",  64'(glitch),  64'd0);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    bus.no_pre = 1'b1;
    run_frame(1'b0, 5'h01, 5'h00, 16'h1140, '1, -1, -1, 1'b0,
              cap_o, cap_t, busy_len, done_cnt, done_at, glitch);
    bus.no_pre = 1'b0;
    chk("nopre_frame",    {32'd0, cap_o[63:32]}, 64'h5082_1140);
    chk("nopre_done_at",  64'(done_at),  64'd128);
    chk("nopre_busy_len", 64'(busy_len), 64'd128);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mdio_master.md
MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 Parameter CLK_DIV, default 10: MDC half-period in clk cycles; legal range 2..255.
REQ-002 clk  input  1  single system clock; all logic runs on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request; sampled in IDLE only.
REQ-005 op_read  input  1  1 = read frame, 0 = write frame; sampled with start.
REQ-006 phy_addr  input  5  PHY address; sampled with start.
REQ-007 reg_addr  input  5  register address; sampled with start.
REQ-008 wr_data  input  16  write payload; sampled with start.
REQ-009 busy  output  1  frame in progress.
REQ-010 done  output  1  one-cycle pulse at frame end.
REQ-011 rd_data  output  16  last read payload; holds until the next read completes.
REQ-012 rd_err  output  1  second TA bit sampled 1 on the last read (no PHY responded).
REQ-013 mdc  output  1  management clock.
REQ-014 mdio_o  output  1  serial data toward the pad buffer.
REQ-015 mdio_t  output  1  1 = drive pad with mdio_o; 0 = release (pad enable polarity of gpio_tristate_io).
REQ-016 mdio_i  input  1  pad read-back.

Function
REQ-017 The block SHALL generate Clause-22 frames, 64 bits, MSB first: 32 ones (preamble), ST=01, OP (01 write / 10 read), phy_addr, reg_addr, TA, 16 data bits.
REQ-018 Bit timing SHALL be: 2*CLK_DIV clk cycles per bit; mdc low for the first CLK_DIV cycles and high for the next CLK_DIV; mdio_o updates at bit start; mdio_i is sampled on the clk edge that raises mdc.
REQ-019 Start accepted at edge N SHALL give busy=1 from N+1 for exactly 128*CLK_DIV cycles; done=1 for one cycle on the edge that clears busy.
REQ-020 start while busy SHALL be ignored; latched fields SHALL stay constant for the whole frame.
REQ-021 FSM states SHALL be IDLE -> PRE (32 bits) -> HDR (14 bits) -> TA (2 bits) -> DATA (16 bits) -> IDLE; no other transitions except reset.
REQ-022 Write frames SHALL keep mdio_t=1 for all 64 bits and drive TA=10.
REQ-023 Read frames SHALL keep mdio_t=1 for bits 0..45 and mdio_t=0 for bits 46..63.
REQ-024 On a read, the TA bit-2 sample SHALL be loaded into rd_err, and rd_data SHALL be loaded from the data samples in the same cycle done pulses.
REQ-025 A write SHALL leave rd_data and rd_err unchanged.
REQ-026 In IDLE: mdc=0, mdio_t=0, mdio_o=1.
REQ-027 start in the same cycle done pulses SHALL be ignored; a new frame needs start while busy=0 and done=0.

Reset
REQ-028 rst SHALL immediately force: busy=0, done=0, rd_data=16'h0000, rd_err=0, mdc=0, mdio_o=1, mdio_t=0, FSM=IDLE, divider and bit counters=0.
REQ-029 rst mid-frame SHALL abandon the frame with no done pulse; after release, the next start SHALL produce a full 64-bit frame.

Configuration
REQ-030 Macro MDIO_PREAMBLE_SUPPRESS_EN defined: add input no_pre (1 bit, sampled with start); no_pre=1 skips PRE, the frame is 32 bits, and busy lasts 64*CLK_DIV cycles.
REQ-031 Macro MDIO_PREAMBLE_SUPPRESS_EN undefined: no no_pre port; every frame carries the full preamble.

Structure
REQ-032 Shared package mdio_pkg SHALL hold the ST/OP encodings, PREAMBLE_LEN=32, FRAME_LEN=64 and the FSM state encoding.
REQ-033 Sub-module mdc_clk_gen SHALL implement the CLK_DIV divider and emit one-cycle bit_start and mdc_rise strobes; all FSM logic stays in mdio_master.

Verification
REQ-034 Write, CLK_DIV=2, phy=5'h01, reg=5'h00, wr_data=16'h1140 -> mdio_o bits 32..63 = 01 01 00001 00000 10 0001000101000000; mdio_t=1 throughout; done after 256 cycles.
REQ-035 Read, phy=5'h02, reg=5'h03, PHY model returns TA=0 and 16'h0D81 -> rd_data=16'h0D81, rd_err=0, mdio_t=0 from bit 46.
REQ-036 Read with mdio_i pulled high (no PHY) -> rd_data=16'hFFFF, rd_err=1.
REQ-037 Second start pulsed at bit 20 of a frame -> ignored; exactly one done; the frame content is unchanged.
REQ-038 rst asserted at bit 40 -> outputs at reset values within the same cycle, no done; the next write completes normally.
REQ-039 MDIO_PREAMBLE_SUPPRESS_EN defined, no_pre=1, CLK_DIV=2 -> first driven bits are 01; done after 128 cycles.
